display_mux_bcd: RTL and testbench
==================================

Name: display_mux_bcd

Overview:
- Parametrised successor to the combinational debug-display path: selects one of N_CH 32-bit processor observation channels (PC, registers), snapshots it periodically, and converts it to decimal with a sequential shift-add-3 (double-dabble) engine.
- Drives N_DIGITS active-low 7-segment digits with leading-zero blanking and overflow indication.
- Sits between the datapath observation bus and the board's HEX displays.
- Replaces division/modulo logic with a multi-cycle converter.

Parameters:
- DATA_W, 32, width of each channel word.
- N_CH, 5, number of selectable channels.
- SEL_W, 3, width of select; must satisfy 2**SEL_W >= N_CH.
- N_DIGITS, 4, number of decimal digits driven (1..10).
- REFRESH_DIV, 50000, clk cycles between automatic refresh triggers (>= DATA_W+3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ch_data  in  N_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- select  in  SEL_W  channel select (switches); values >= N_CH select constant 0.
- update  in  1  single-cycle request for an immediate conversion.
- segs  out  N_DIGITS*7  active-low segments; digit 0 (ones) in bits [6:0], digit i in [i*7 +: 7]; bit order g..a (MSB = g).
- busy  out  1  high while a conversion is in progress.
- valid  out  1  high once segs holds at least one completed conversion.

Behaviour:
- Reset (reset low, async):
  - segs all 1s (blank), busy 0, valid 0.
  - Refresh counter 0, pending flag 0, FSM IDLE.
- Refresh counter:
  - Free-runs 0..REFRESH_DIV-1, wraps to 0.
  - A trigger occurs when the counter equals REFRESH_DIV-1, or when update is high.
- Pending flag:
  - A trigger in any state other than IDLE sets pending (at most one queued request).
  - Cleared on entry to LOAD.
- FSM states:
  - IDLE: on trigger or pending -> LOAD.
  - LOAD (1 cycle):
    - Capture the selected channel into a shift register (0 if select >= N_CH).
    - Clear the BCD accumulator (N_DIGITS*4 bits) and the overflow flag.
    - Load the bit counter with DATA_W. busy=1.
  - SHIFT (exactly DATA_W cycles):
    - Each cycle, add 3 to every BCD digit >= 5.
    - Then shift {bcd, bin} left by 1.
    - If the bit leaving the top BCD digit is 1, set overflow (sticky for this conversion).
  - DONE (1 cycle):
    - Encode digits into segs. valid<=1, busy<=0.
    - -> IDLE; a set pending flag starts the next conversion from IDLE.
- Latency: trigger at cycle T (sampled in IDLE) -> LOAD at T+1 -> segs updated at T+DATA_W+2 (34 cycles for DATA_W=32). busy is high for DATA_W+2 cycles.
- segs holds its previous value throughout a conversion; no intermediate values are visible.
- Encoding, digits 0..9, active-low: 40,79,24,30,19,12,02,78,00,10 hex.
- Leading-zero blanking:
  - Digit i>0 is blank (7'h7F) when it and all higher digits are 0.
  - Digit 0 is always shown (value 0 displays "0").
- Overflow (value >= 10**N_DIGITS): every digit shows dash 7'h3F; blanking is not applied.
- select changes mid-conversion have no effect until the next LOAD.
- Reset asserted mid-conversion aborts it; all outputs return to reset values immediately.

Optional Feature:
- Macro: DISP_HEX_MODE_EN.
- Defined:
  - Adds input port hex_mode (1 bit), sampled in LOAD.
  - When 1, SHIFT is skipped: LOAD -> DONE, latency 2 cycles.
  - segs shows the low N_DIGITS nibbles of the captured word.
  - Hex glyphs A..F: 08,03,46,21,06,0E.
  - No leading-zero blanking in hex mode.
  - Overflow dashes when any bit above N_DIGITS*4 is set.
- Undefined: no hex_mode port; decimal only.

Test Plan (defaults, REFRESH_DIV=64 for simulation):
- Reset release, no trigger -> segs=28'hFFFFFFF, valid=0, busy=0; first auto trigger -> valid=1 after 34 cycles.
- Channel 2 = 1234, select=2, update pulse -> after 34 cycles, digits 3..0 = 79,24,30,19; busy high exactly 34 cycles.
- Channel 0 = 7, select=0 -> digits 3..1 blank 7F, digit 0 = 78; channel 0 = 0 -> digit 0 = 40, others 7F.
- Channel 1 = 10000 (and 32'hFFFFFFFF) -> all four digits 3F; channel 1 = 9999 -> 10,10,10,10.
- select=7 -> displays "0". Second update pulse 5 cycles into a conversion -> exactly one further conversion follows back-to-back, and segs reflects the select value at the second LOAD.
- Assert reset at SHIFT cycle 10 -> segs blank, valid=0, busy=0 immediately; after release, normal operation resumes.

Source files
------------

// File: rtl/display_mux_bcd.sv
// -----------------------------------------------------------------------------
// display_mux_bcd
//
// Selects one of N_CH observation channels, snapshots it on a periodic refresh
// tick or on request, converts it to decimal with a sequential shift-add-3
// (double-dabble) engine and drives N_DIGITS active-low 7-segment digits with
// leading-zero blanking and overflow dashes.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   ch_data   in   N_CH*DATA_W packed channels, channel k at [k*DATA_W +: DATA_W]
//   select    in   channel select; values >= N_CH select constant 0
//   update    in   single-cycle request for an immediate conversion
//   hex_mode  in   (only with DISP_HEX_MODE_EN) show low nibbles in hex, sampled in LOAD
//   segs      out  active-low segments, digit i at [i*7 +: 7], bit order g..a
//   busy      out  high while a conversion is in progress
//   valid     out  high once segs holds at least one completed conversion
//
// Optional feature macro: DISP_HEX_MODE_EN (adds the hex_mode port).
// -----------------------------------------------------------------------------
module display_mux_bcd #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned N_CH        = 5,
   parameter int unsigned SEL_W       = 3,
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH*DATA_W-1:0] ch_data,
   input  logic [SEL_W-1:0]       select,
   input  logic                   update,
`ifdef DISP_HEX_MODE_EN
   input  logic                   hex_mode,
`endif
   output logic [N_DIGITS*7-1:0]  segs,
   output logic                   busy,
   output logic                   valid
);

   localparam int unsigned BCD_W = N_DIGITS * 4;
   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic [DATA_W-1:0]     bin_q, bin_d;
   logic [BCD_W-1:0]      bcd_q, bcd_d;
   logic                  ovf_q, ovf_d;
   logic [BIT_W-1:0]      bits_q, bits_d;
   logic [N_DIGITS*7-1:0] segs_q, segs_d;
   logic                  busy_q, busy_d;
   logic                  valid_q, valid_d;
`ifdef DISP_HEX_MODE_EN
   logic                  hex_q, hex_d;
   logic [DATA_W+BCD_W-1:0] bin_pad;
   logic                  hex_ovf;
   logic [N_DIGITS*7-1:0] disp_hex;
`endif

   logic                  trigger;
   logic [DATA_W-1:0]     sel_word;
   logic [BCD_W-1:0]      bcd_adj;
   logic [N_DIGITS*7-1:0] disp_dec;
   logic                  zero_run;

   // Active-low glyphs, bit order g..a; A..F only reachable in hex mode.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      seg7 = 7'h7F;
      case (d)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         4'hF: seg7 = 7'h0E;
      endcase
   endfunction

   // Channel mux; out-of-range select falls through to zero.
   always_comb begin
      sel_word = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (select == SEL_W'(k)) sel_word = ch_data[k*DATA_W +: DATA_W];
      end
   end

   // Add-3 correction applied to every BCD digit before each shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
   end

   // Decimal display image; walks from the top digit so zero_run tracks
   // whether every digit above (and including) the current one is zero.
   always_comb begin
      disp_dec = '1;
      zero_run = 1'b1;
      for (int unsigned k = N_DIGITS; k > 0; k--) begin
         if (bcd_q[(k-1)*4 +: 4] != 4'd0) zero_run = 1'b0;
         if (ovf_q)
            disp_dec[(k-1)*7 +: 7] = 7'h3F;
         else if (zero_run && (k > 1))
            disp_dec[(k-1)*7 +: 7] = 7'h7F;
         else
            disp_dec[(k-1)*7 +: 7] = seg7(bcd_q[(k-1)*4 +: 4]);
      end
   end

`ifdef DISP_HEX_MODE_EN
   // Zero-padded copy so the nibble slice stays in range for any N_DIGITS.
   always_comb begin
      bin_pad  = {{BCD_W{1'b0}}, bin_q};
      hex_ovf  = |(bin_pad >> BCD_W);
      disp_hex = '1;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
         disp_hex[k*7 +: 7] = hex_ovf ? 7'h3F : seg7(bin_pad[k*4 +: 4]);
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      bits_d  = bits_q;
      segs_d  = segs_q;
      busy_d  = busy_q;
      valid_d = valid_q;
`ifdef DISP_HEX_MODE_EN
      hex_d   = hex_q;
`endif

      cnt_d   = (cnt_q == CNT_W'(REFRESH_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
      trigger = update || (cnt_q == CNT_W'(REFRESH_DIV - 1));

      if (trigger && (state_q != S_IDLE)) pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (trigger || pend_q) begin
               state_d = S_LOAD;
               pend_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_LOAD: begin
            bin_d   = sel_word;
            bcd_d   = '0;
            ovf_d   = 1'b0;
            bits_d  = BIT_W'(DATA_W);
            state_d = S_SHIFT;
`ifdef DISP_HEX_MODE_EN
            hex_d   = hex_mode;
            if (hex_mode) state_d = S_DONE;
`endif
         end
         S_SHIFT: begin
            // A 1 leaving the top digit means the value needs more digits.
            if (bcd_adj[BCD_W-1]) ovf_d = 1'b1;
            bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
            bin_d  = {bin_q[DATA_W-2:0], 1'b0};
            bits_d = bits_q - BIT_W'(1);
            if (bits_q == BIT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
`ifdef DISP_HEX_MODE_EN
            segs_d  = hex_q ? disp_hex : disp_dec;
`else
            segs_d  = disp_dec;
`endif
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         bin_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         bits_q  <= '0;
         segs_q  <= '1;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef DISP_HEX_MODE_EN
         hex_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         bits_q  <= bits_d;
         segs_q  <= segs_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
`ifdef DISP_HEX_MODE_EN
         hex_q   <= hex_d;
`endif
      end
   end

   assign segs  = segs_q;
   assign busy  = busy_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_display_mux_bcd.sv
module tb_display_mux_bcd;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned N_CH     = 5;
   localparam int unsigned SEL_W    = 3;
   localparam int unsigned N_DIGITS = 4;
   localparam int unsigned REFRESH  = 64;
   localparam int unsigned LAT      = DATA_W + 2;
   localparam int unsigned SW       = N_DIGITS * 7;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [DATA_W-1:0]      ch [N_CH];
   logic [N_CH*DATA_W-1:0] ch_data;
   logic [SEL_W-1:0]       select = '0;
   logic                   update = 1'b0;
   logic [SW-1:0]          segs;
   logic                   busy;
   logic                   valid;

   always #5 clk = ~clk;

   always_comb begin
      ch_data = '0;
      for (int k = 0; k < N_CH; k++) ch_data[k*DATA_W +: DATA_W] = ch[k];
   end

   display_mux_bcd #(
      .DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W),
      .N_DIGITS(N_DIGITS), .REFRESH_DIV(REFRESH)
   ) dut (
      .clk(clk), .reset(reset), .ch_data(ch_data), .select(select),
      .update(update), .segs(segs), .busy(busy), .valid(valid)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: glyph = 7'h40; 1: glyph = 7'h79; 2: glyph = 7'h24; 3: glyph = 7'h30;
         4: glyph = 7'h19; 5: glyph = 7'h12; 6: glyph = 7'h02; 7: glyph = 7'h78;
         8: glyph = 7'h00; 9: glyph = 7'h10;
         default: glyph = 7'h7F;
      endcase
   endfunction

   function automatic logic [SW-1:0] ref_segs(input logic [DATA_W-1:0] v);
      longint vv, p, lim;
      ref_segs = '1;
      vv  = longint'(v);
      lim = 1;
      for (int i = 0; i < N_DIGITS; i++) lim = lim * 10;
      p = 1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (vv >= lim)              ref_segs[i*7 +: 7] = 7'h3F;
         else if (i > 0 && vv < p)   ref_segs[i*7 +: 7] = 7'h7F;
         else                        ref_segs[i*7 +: 7] = glyph(int'((vv / p) % 10));
         p = p * 10;
      end
   endfunction

   typedef struct {
      logic [SW-1:0] segs;
      int            due;
   } exp_t;
   exp_t exp_q[$];

   // Edge-indexed timing model: edge e sees refresh count e % REFRESH.
   int e         = 0;
   int last_edge = 0;
   int cap_at    = -1;
   int next_idle = 0;
   bit pend      = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         e = 0; cap_at = -1; next_idle = 0; pend = 1'b0;
         exp_q.delete();
      end else begin
         bit trig;
         exp_t x;
         trig = update || ((e % REFRESH) == REFRESH - 1);
         if (e == cap_at) begin
            x.segs = ref_segs((select < N_CH) ? ch[select] : '0);
            x.due  = e + LAT - 1;
            exp_q.push_back(x);
         end
         if (e < next_idle) begin
            if (trig) pend = 1'b1;
         end else if (trig || pend) begin
            pend      = 1'b0;
            cap_at    = e + 1;
            next_idle = e + LAT + 1;
         end
         last_edge = e;
         e++;
      end
   end

   // ---------------- monitor ----------------
   bit            busy_prev = 1'b0;
   bit            changed   = 1'b0;
   int            busy_len  = 0;
   logic [SW-1:0] seg_hold;

   always @(negedge clk) begin
      if (!reset) begin
         busy_prev = 1'b0; busy_len = 0; changed = 1'b0;
      end else begin
         if (busy) begin
            if (!busy_prev) begin
               seg_hold = segs; busy_len = 0; changed = 1'b0;
            end
            busy_len++;
            if (segs !== seg_hold) changed = 1'b1;
         end else if (busy_prev) begin
            if (exp_q.size() == 0) begin
               check("spurious_result", 64'(exp_q.size()), 64'd1);
            end else begin
               exp_t x;
               x = exp_q.pop_front();
               check("segs",         segs,            x.segs);
               check("latency_edge", 64'(last_edge),  64'(x.due));
               check("busy_cycles",  64'(busy_len),   64'(LAT));
               check("valid",        valid,           1'b1);
               check("segs_held",    changed,         1'b0);
            end
            done_cnt++;
         end
         busy_prev = busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_done(input string name);
      int start, n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (done_cnt == start) begin
         n_checks++;
         $display("FAIL %s: no result within %0d cycles, got none required one", name, n);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(e >= next_idle && !pend && exp_q.size() == 0) && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
   endtask

   task automatic pulse_update();
      @(posedge clk); #1 update = 1'b1;
      @(posedge clk); #1 update = 1'b0;
   endtask

   task automatic run_one(input int k, input logic [DATA_W-1:0] v, input logic [SEL_W-1:0] sel,
                          input string name, input logic [SW-1:0] want);
      wait_idle();
      @(posedge clk); #1;
      if (k < N_CH) ch[k] = v;
      select = sel;
      pulse_update();
      wait_done(name);
      check(name, segs, want);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < N_CH; k++) ch[k] = '0;
      ch[0] = 32'd42;
      repeat (3) @(posedge clk);
      #1;
      check("reset_segs",  segs,  {SW{1'b1}});
      check("reset_busy",  busy,  1'b0);
      check("reset_valid", valid, 1'b0);
      @(negedge clk) reset = 1'b1;

      repeat (20) @(posedge clk);
      #2;
      check("idle_segs",  segs,  {SW{1'b1}});
      check("idle_busy",  busy,  1'b0);
      check("idle_valid", valid, 1'b0);

      wait_done("first_auto");
      check("first_auto_valid", valid, 1'b1);

      run_one(2, 32'd1234,     3'd2, "dec_1234",  {7'h79, 7'h24, 7'h30, 7'h19});
      run_one(0, 32'd7,        3'd0, "dec_7",     {7'h7F, 7'h7F, 7'h7F, 7'h78});
      run_one(0, 32'd0,        3'd0, "dec_0",     {7'h7F, 7'h7F, 7'h7F, 7'h40});
      run_one(1, 32'd10000,    3'd1, "ovf_10000", {4{7'h3F}});
      run_one(1, 32'hFFFFFFFF, 3'd1, "ovf_max",   {4{7'h3F}});
      run_one(1, 32'd9999,     3'd1, "dec_9999",  {4{7'h10}});
      run_one(N_CH, '0,        3'd7, "sel_oob",   {7'h7F, 7'h7F, 7'h7F, 7'h40});

      // Second request 5 cycles into a conversion queues exactly one more.
      wait_idle();
      @(posedge clk); #1;
      ch[1] = 32'd1111; ch[3] = 32'd3333; select = 3'd1;
      pulse_update();
      repeat (4) @(posedge clk);
      #1 select = 3'd3; update = 1'b1;
      @(posedge clk); #1 update = 1'b0;
      wait_done("b2b_first");
      check("b2b_first", segs, {4{7'h79}});
      wait_done("b2b_second");
      check("b2b_second", segs, {4{7'h30}});

      for (int it = 0; it < 16; it++) begin
         wait_idle();
         @(posedge clk); #1;
         for (int k = 0; k < N_CH; k++) begin
            case ($urandom_range(0, 3))
               0:       ch[k] = $urandom;
               1:       ch[k] = $urandom_range(0, 9999);
               2:       ch[k] = $urandom_range(0, 99);
               default: ch[k] = $urandom_range(9990, 10010);
            endcase
         end
         select = SEL_W'($urandom_range(0, 7));
         pulse_update();
         wait_done("random");
      end

      // Reset during the SHIFT phase aborts the conversion immediately.
      wait_idle();
      @(posedge clk); #1;
      ch[2] = 32'd4321; select = 3'd2;
      pulse_update();
      repeat (10) @(posedge clk);
      #3;
      check("busy_before_reset", busy, 1'b1);
      reset = 1'b0;
      #1;
      check("abort_segs",  segs,  {SW{1'b1}});
      check("abort_busy",  busy,  1'b0);
      check("abort_valid", valid, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #2;
      check("post_reset_valid", valid, 1'b0);
      run_one(3, 32'd5678, 3'd3, "resume_5678", {7'h12, 7'h02, 7'h78, 7'h00});
      check("resume_valid", valid, 1'b1);

      wait_idle();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
